dmem_arbiter: RTL

Arbiter for the data-side port (port B) of the shared byte-addressable BRAM, sharing it between the pipeline's load/store unit (core requester) and a host requester (program loader / debug access). It grants one single-cycle access per clock, tracks which requester owns the in-flight synchronous read, and returns read data with a valid strobe one cycle later. It raises a stall toward the pipeline whenever a core access is not granted, and bounds host lock bursts so the core cannot starve.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Port-B arbiter for the shared data BRAM: core LSU vs. host loader/debug.
// Optional round-robin IDLE arbitration when DMEM_ARB_RR_EN is defined.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic [3:0]    c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic [3:0]    h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_lock,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic [3:0]    web,
  output logic [AW-1:0] addrb,
  output logic [DW-1:0] dib,
  input  logic [DW-1:0] dob
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic { IDLE, HOST_LOCK } state_t;
  typedef enum logic [1:0] { RD_NONE, RD_CORE, RD_HOST } rd_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_lock_cnt, w_lock_cnt_n;
  logic          r_last_gnt, w_last_gnt_n;
  rd_t           r_rd_owner, w_rd_owner_n;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          w_c_gnt, w_h_gnt;

  always_comb begin
    w_c_gnt      = 1'b0;
    w_h_gnt      = 1'b0;
    w_state_n    = r_state;
    w_lock_cnt_n = r_lock_cnt;
    w_last_gnt_n = r_last_gnt;
    // Grants are gated by reset so nothing reaches the BRAM while held in reset.
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (c_req && h_req) begin
`ifdef DMEM_ARB_RR_EN
            if (r_last_gnt) w_c_gnt = 1'b1;
            else            w_h_gnt = 1'b1;
`else
            w_h_gnt = 1'b1;
`endif
          end else begin
            w_c_gnt = c_req;
            w_h_gnt = h_req;
          end
        end
        HOST_LOCK: begin
          if (!h_req)                                    w_c_gnt = c_req;
          else if (r_lock_cnt == CW'(LOCK_MAX) && c_req) w_c_gnt = 1'b1;
          else                                           w_h_gnt = 1'b1;
        end
        default: ;
      endcase
    end

    if (w_h_gnt) begin
      w_last_gnt_n = 1'b1;
      if (h_lock) begin
        w_state_n = HOST_LOCK;
        if (r_lock_cnt != CW'(LOCK_MAX)) w_lock_cnt_n = r_lock_cnt + CW'(1);
      end else begin
        w_state_n    = IDLE;
        w_lock_cnt_n = '0;
      end
    end else if (w_c_gnt) begin
      w_last_gnt_n = 1'b0;
      w_lock_cnt_n = '0;
      // A forced core slot keeps the host lock alive if the host still wants it.
      w_state_n    = (r_state == HOST_LOCK && h_req && h_lock) ? HOST_LOCK : IDLE;
    end else if (r_state == HOST_LOCK && !h_req) begin
      w_state_n    = IDLE;
      w_lock_cnt_n = '0;
    end
  end

  always_comb begin
    web   = 4'h0;
    addrb = r_addr;
    dib   = r_din;
    if (w_c_gnt) begin
      web   = c_we;
      addrb = c_addr;
      dib   = c_wdata;
    end else if (w_h_gnt) begin
      web   = h_we;
      addrb = h_addr;
      dib   = h_wdata;
    end
  end

  always_comb begin
    w_rd_owner_n = RD_NONE;
    if (w_c_gnt && c_we == 4'h0)      w_rd_owner_n = RD_CORE;
    else if (w_h_gnt && h_we == 4'h0) w_rd_owner_n = RD_HOST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_last_gnt <= 1'b0;
      r_rd_owner <= RD_NONE;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_lock_cnt <= w_lock_cnt_n;
      r_last_gnt <= w_last_gnt_n;
      r_rd_owner <= w_rd_owner_n;
      r_addr     <= addrb;
      r_din      <= dib;
    end
  end

  assign c_gnt    = w_c_gnt;
  assign h_gnt    = w_h_gnt;
  assign c_stall  = rst_n & c_req & ~w_c_gnt;
  assign c_rvalid = (r_rd_owner == RD_CORE);
  assign h_rvalid = (r_rd_owner == RD_HOST);
  assign c_rdata  = dob;
  assign h_rdata  = dob;
endmodule
